regfile_write_ctrl: RTL and testbench
=====================================

# regfile_write_ctrl

Write-back controller for the integer register file: the write side paired with the register select/read logic. Accepts write-back requests from execute, buffers them in a small FIFO, and drains one registered write per cycle into the 32 x 32-bit register file. Keeps a per-register busy scoreboard so issue logic can detect RAW and WAW hazards against in-flight writes. Register x0 is never written and never marked busy.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (32 registers)
- DEPTH, 4, write-back FIFO entries (power of 2, >= 2)

- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- reserve_valid  input  1  issue stage requests a destination reservation
- reserve_addr  input  ADDR_WIDTH  destination register to reserve
- reserve_ready  output  1  combinational: high when reserve_addr is 0 or not busy
- wb_valid  input  1  write-back request valid
- wb_addr  input  ADDR_WIDTH  write-back destination
- wb_data  input  DATA_WIDTH  write-back value
- wb_ready  output  1  combinational: high when FIFO not full
- rf_stall  input  1  register file cannot take a write this cycle
- rf_we  output  1  registered write enable to register file
- rf_waddr  output  ADDR_WIDTH  registered write address
- rf_wdata  output  DATA_WIDTH  registered write data
- busy  output  32  scoreboard, bit i high while a write to xi is reserved or pending; bit 0 always 0
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
- err_unreserved  output  1  sticky: a write-back arrived for a non-busy, non-zero register

## Operation
- Reservation accepted when reserve_valid && reserve_ready; sets busy[reserve_addr] at the edge. Address 0: accepted, no effect.
- Write-back accepted when wb_valid && wb_ready. Address 0: accepted, discarded, not enqueued, no error. Any other address is enqueued at the tail.
- If an accepted non-zero wb_addr has busy low (and no reservation of it in the same cycle), set err_unreserved. The write is still enqueued and performed. Cleared only by rst.
- Drain: if FIFO non-empty and !rf_stall, pop the head. At that edge, rf_we <= 1 and rf_waddr/rf_wdata <= head. busy[head addr] clears at the same edge. Otherwise rf_we <= 0; rf_waddr/rf_wdata hold their last values.
- Writes leave in acceptance order. At most one enqueue and one dequeue per cycle.
- Enqueue and dequeue in the same cycle leave fifo_count unchanged.
- wb_ready depends on full only: a full FIFO rejects even when a pop occurs that cycle.
- Reserve and clear of the same address in one cycle cannot occur, because reserve_ready is low while busy is set. When a reserve of address A coincides with a pop of a different address B, set busy[A] and clear busy[B].
- Reservation of an address already busy is refused (WAW stall); the issuer holds its request.
- busy is held until the write leaves the FIFO, not merely when it is accepted.

## Timing
- Reset (async assert, sync release): FIFO empty, fifo_count=0, busy=0, rf_we=0, rf_waddr=0, rf_wdata=0, err_unreserved=0. wb_ready=1 and reserve_ready=1 during and after reset.
- Latency: write-back accepted at edge N into an empty FIFO, with rf_stall low at N+1. The entry pops at N+1, so rf_we is high in the cycle after edge N+1 (2 edges). No bypass path.
- busy[i] rises the edge after reservation. It falls on the same edge that rf_we for xi is registered high.
- Sustained throughput is 1 write/cycle with rf_stall low.
- rf_stall high freezes the FIFO head and drops rf_we the following cycle. Enqueue continues until full.
- Pointers wrap modulo DEPTH. Full = count == DEPTH, empty = count == 0.
- rst asserted mid-operation discards all pending writes and reservations immediately. No rf_we is asserted after reset is asserted.

## Test plan
- Reset, reserve x5, then wb x5=0xDEADBEEF -> busy[5] high for 2 cycles after the wb; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF exactly 2 edges after acceptance; then busy[5]=0 and err_unreserved=0.
- Hold rf_stall=1, push 5 writes to x1..x5, all reserved -> 4 accepted, wb_ready=0 on the 5th with fifo_count=4. Release stall -> writes x1..x4 in order on consecutive cycles, then x5 once accepted.
- wb to x0 with data 0x12345678 -> no rf_we, fifo_count stays 0, err_unreserved stays 0. reserve x0 -> busy stays 0.
- reserve x7 twice back-to-back -> second cycle reserve_ready=0. After the wb x7 pops, reserve_ready=1 in the following cycle.
- wb to x9 with no reservation -> err_unreserved=1 sticky, and the write is still performed (rf_waddr=9).
- Push 3 writes, assert rst mid-drain -> all outputs return to reset values asynchronously; after release, no pending write appears on rf_we.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl
// Write-back side of the integer register file. Execute pushes write-back
// requests into a small FIFO. The FIFO drains one registered write per cycle
// into the register file. A per-register busy scoreboard lets issue logic see
// RAW/WAW hazards against writes that are still in flight. x0 is never written
// and is never marked busy.
module regfile_write_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reserve_valid,
    input  logic [ADDR_WIDTH-1:0]      reserve_addr,
    output logic                       reserve_ready,
    input  logic                       wb_valid,
    input  logic [ADDR_WIDTH-1:0]      wb_addr,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    output logic                       wb_ready,
    input  logic                       rf_stall,
    output logic                       rf_we,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    output logic [31:0]                busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_unreserved
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage (no reset needed: only entries below count are ever read)
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]         count_reg, count_next;
    logic [31:0]           busy_reg, busy_next;
    logic                  rf_we_reg;
    logic [ADDR_WIDTH-1:0] rf_waddr_reg;
    logic [DATA_WIDTH-1:0] rf_wdata_reg;
    logic                  err_reg;

    logic                  fifo_full, fifo_empty;
    logic                  push, pop, reserve_fire, wb_fire, unreserved_hit;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign head_addr  = addr_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];

    // wb_ready looks at fullness only, so a same-cycle pop never frees a slot early
    assign wb_ready      = !fifo_full;
    assign reserve_ready = (reserve_addr == '0) || !busy_reg[reserve_addr];

    assign reserve_fire = reserve_valid && reserve_ready && (reserve_addr != '0);
    assign wb_fire      = wb_valid && wb_ready;
    assign push         = wb_fire && (wb_addr != '0);
    assign pop          = !fifo_empty && !rf_stall;

    // A write to a register nobody reserved (a reservation in the same cycle counts)
    assign unreserved_hit = push && !busy_reg[wb_addr] &&
                            !(reserve_fire && (reserve_addr == wb_addr));

    // Next scoreboard bit per register: a reservation sets it, a pop of that register clears it
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_bit, clr_bit;
                assign set_bit = reserve_fire && (reserve_addr == ADDR_WIDTH'(gi));
                assign clr_bit = pop && (head_addr == ADDR_WIDTH'(gi));
                assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
            end
        end
    endgenerate

    // Occupancy update: a simultaneous push and pop leave it unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO entry write at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= wb_addr;
            data_mem[wr_ptr_reg] <= wb_data;
        end
    end

    // Pointers, occupancy, scoreboard, sticky error and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            busy_reg     <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            count_reg <= count_next;
            busy_reg  <= busy_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + PW'(1);
                rf_waddr_reg <= head_addr;
                rf_wdata_reg <= head_data;
            end
            rf_we_reg <= pop;
            if (unreserved_hit)
                err_reg <= 1'b1;
        end
    end

    assign rf_we          = rf_we_reg;
    assign rf_waddr       = rf_waddr_reg;
    assign rf_wdata       = rf_wdata_reg;
    assign busy           = busy_reg;
    assign fifo_count     = count_reg;
    assign err_unreserved = err_reg;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed testbench for regfile_write_ctrl. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_regfile_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        reserve_valid;
    logic [4:0]  reserve_addr;
    logic        reserve_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic [2:0]  fifo_count;
    logic        err_unreserved;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr), .reserve_ready(reserve_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .fifo_count(fifo_count), .err_unreserved(err_unreserved)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reserve(input logic [4:0] a);
        reserve_valid = 1'b1;
        reserve_addr  = a;
        $display("reserve x%0d ready=%0b", a, reserve_ready);
        tick();
        reserve_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; reserve_valid = 0; reserve_addr = 0;
        wb_valid = 0; wb_addr = 0; wb_data = 0; rf_stall = 0;
        #12;
        // ---- reset values
        check("rst_rf_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_err", err_unreserved, 0);
        check("rst_wb_ready", wb_ready, 1);
        check("rst_res_ready", reserve_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // ---- basic reserve + write-back of x5
        reserve(5'd5);
        check("t1_busy5_set", busy[5], 1);
        wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        check("t1_wb_ready", wb_ready, 1);
        $display("wb x5 = 0xdeadbeef");
        tick();                                   // edge N: enqueue
        wb_valid = 0;
        check("t1_count_1", fifo_count, 1);
        check("t1_busy5_hold", busy[5], 1);
        check("t1_we_early", rf_we, 0);
        tick();                                   // edge N+1: pop
        check("t1_we", rf_we, 1);
        check("t1_waddr", rf_waddr, 5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        check("t1_busy5_clr", busy[5], 0);
        check("t1_count_0", fifo_count, 0);
        tick();
        check("t1_we_drop", rf_we, 0);
        check("t1_err", err_unreserved, 0);

        // ---- stall fills the FIFO, then in-order drain
        rf_stall = 1;
        for (int i = 1; i <= 5; i++) reserve(5'(i));
        check("t2_busy", busy, 32'h0000_003E);
        for (int i = 1; i <= 5; i++) begin
            wb_valid = 1; wb_addr = 5'(i); wb_data = 32'h100 + i;
            check($sformatf("t2_wb_ready_%0d", i), wb_ready, (i <= 4) ? 1 : 0);
            $display("wb x%0d = 0x%0h ready=%0b", i, 32'h100 + i, wb_ready);
            if (i <= 4) tick();
        end
        check("t2_full_count", fifo_count, 4);
        rf_stall = 0;                              // x5 request held
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) wb_valid = 0;              // x5 accepted at the 2nd edge
            check($sformatf("t2_we_%0d", k), rf_we, 1);
            check($sformatf("t2_waddr_%0d", k), rf_waddr, k);
            check($sformatf("t2_wdata_%0d", k), rf_wdata, 32'h100 + k);
            check($sformatf("t2_count_%0d", k), fifo_count, (k <= 2) ? 3 : 5 - k);
        end
        tick();
        check("t2_busy_clear", busy, 0);
        check("t2_err", err_unreserved, 0);

        // ---- writes and reservations of x0
        wb_valid = 1; wb_addr = 0; wb_data = 32'h12345678;
        check("t3_wb_ready", wb_ready, 1);
        $display("wb x0 = 0x12345678");
        tick();
        wb_valid = 0;
        check("t3_count", fifo_count, 0);
        tick();
        check("t3_we", rf_we, 0);
        check("t3_err", err_unreserved, 0);
        reserve_addr = 0;
        check("t3_res_ready", reserve_ready, 1);
        reserve(5'd0);
        check("t3_busy", busy, 0);

        // ---- WAW: double reservation of x7
        reserve_valid = 1; reserve_addr = 7;
        $display("reserve x7 held");
        tick();
        check("t4_busy7", busy[7], 1);
        check("t4_ready_low1", reserve_ready, 0);
        tick();
        check("t4_ready_low2", reserve_ready, 0);
        reserve_valid = 0;
        wb_valid = 1; wb_addr = 7; wb_data = 32'h77;
        $display("wb x7 = 0x77");
        tick();
        wb_valid = 0;
        check("t4_ready_low3", reserve_ready, 0);
        tick();
        check("t4_we", rf_we, 1);
        check("t4_waddr", rf_waddr, 7);
        check("t4_ready_high", reserve_ready, 1);
        check("t4_err", err_unreserved, 0);

        // ---- unreserved write to x9
        wb_valid = 1; wb_addr = 9; wb_data = 32'h99;
        $display("wb x9 = 0x99 (unreserved)");
        tick();
        wb_valid = 0;
        check("t5_err_set", err_unreserved, 1);
        tick();
        check("t5_we", rf_we, 1);
        check("t5_waddr", rf_waddr, 9);
        check("t5_wdata", rf_wdata, 32'h99);
        tick();
        check("t5_err_sticky", err_unreserved, 1);

        // ---- reset in the middle of a drain
        rf_stall = 1;
        for (int i = 10; i <= 12; i++) reserve(5'(i));
        for (int i = 10; i <= 12; i++) begin
            wb_valid = 1; wb_addr = 5'(i); wb_data = 32'hA00 + i;
            $display("wb x%0d = 0x%0h", i, 32'hA00 + i);
            tick();
        end
        wb_valid = 0;
        check("t6_count3", fifo_count, 3);
        rf_stall = 0;
        tick();
        check("t6_we", rf_we, 1);
        check("t6_waddr", rf_waddr, 10);
        #2 rst = 1;
        #1;
        check("t6_rst_we", rf_we, 0);
        check("t6_rst_waddr", rf_waddr, 0);
        check("t6_rst_wdata", rf_wdata, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_err", err_unreserved, 0);
        check("t6_rst_wb_ready", wb_ready, 1);
        tick();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t6_post_we_%0d", k), rf_we, 0);
        end
        check("t6_post_count", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
